pipe_shifter: RTL and testbench
===============================

// Module: pipe_shifter
// PURPOSE
//   Parametrised, pipelined barrel shifter with valid/ready handshake on both sides.
//   Supports logical left, logical right, arithmetic right, rotate left and rotate right.
//   Sits between the issue logic and writeback, beside the ALU in the multi-cycle and pipelined CPUs.
//   A sideband tag travels with each operation so the consumer can match results to requests.
// PARAMETERS
//   DATA_WIDTH   32  operand/result width; power of 2, >= 8
//   PIPE_STAGES  2   register stages, 1..log2(DATA_WIDTH); equals latency when unstalled
//   TAG_WIDTH    4   width of pass-through tag, >= 1
//   (derived) SHAMT_W = log2(DATA_WIDTH); LVL_PER_STG = ceil(SHAMT_W / PIPE_STAGES)
// PORTS
//   clk        in   1               clock, rising edge
//   rst        in   1               asynchronous reset, active-high
//   in_valid   in   1               request valid
//   in_ready   out  1               block accepts request this cycle
//   A          in   DATA_WIDTH      operand
//   B          in   SHAMT_W         shift amount, unsigned
//   Shiftop    in   3               000 LL, 010 RL, 011 RA, 100 ROL, 110 ROR; others reserved
//   in_tag     in   TAG_WIDTH       request tag
//   out_valid  out  1               result valid
//   out_ready  in   1               consumer accepts result
//   Result     out  DATA_WIDTH      shifted value
//   out_tag    out  TAG_WIDTH       tag of the operation on Result
// BEHAVIOUR
//   - Reset (async, while rst=1): every stage valid=0, data/op/tag/shamt regs=0; so out_valid=0,
//     Result=0, out_tag=0; in_ready=1 in the first cycle after release.
//   - Transfer happens on a rising edge where valid & ready are both 1 (either side).
//   - Shift levels k=0..SHAMT_W-1 (shift by 2^k, applied iff B[k]); stage s (1-based) applies levels
//     (s-1)*LVL_PER_STG .. min(s*LVL_PER_STG, SHAMT_W)-1, then registers. Stages with no level pass data.
//   - Each stage register holds {valid, data, B, Shiftop, tag}; Result/out_tag/out_valid come straight
//     from the last stage register (no combinational path from A to Result).
//   - Stage ready: rdy_s = !v_s | rdy_{s+1}; rdy_{PIPE_STAGES+1} = out_ready; in_ready = rdy_1.
//     Bubbles collapse; a stalled stage holds all its contents unchanged.
//   - Latency: accepted at edge t -> out_valid=1 after edge t+PIPE_STAGES-1 (i.e. visible PIPE_STAGES
//     cycles after presentation) if no stall. Throughput 1/cycle with out_ready held 1.
//   - Capacity: exactly PIPE_STAGES operations in flight; with out_ready=0 the block accepts
//     PIPE_STAGES requests then holds in_ready=0. Results leave strictly in acceptance order.
//   - Simultaneous pop and push on a full pipe: allowed same cycle (in_ready=1 when out_ready=1).
//   - Arithmetic: LL fills 0 at LSB; RL fills 0 at MSB; RA fills with A[DATA_WIDTH-1] (original sign);
//     ROL/ROR move bits end-around, no loss. B=0 -> Result=A for all defined ops.
//   - Reserved Shiftop (001,101,111) -> Result=0, still handshaken and tagged as a normal op.
//   - out_valid, Result, out_tag stay stable while out_valid=1 & out_ready=0.
//   - Inputs are ignored when in_valid=0; a non-accepted request (in_ready=0) is not captured.
//   - rst asserted mid-operation: all in-flight ops are discarded immediately; no stale
//     out_valid after release.
// TESTING  (DATA_WIDTH=32, PIPE_STAGES=2, TAG_WIDTH=4, out_ready=1 unless stated)
//   1. LL A=0x00000001 B=31 tag=3 -> out_valid 2 cycles later, Result=0x80000000, out_tag=3.
//   2. A=0x80000000 B=4: RA -> 0xF8000000; RL -> 0x08000000; back-to-back, results on
//      consecutive cycles in order.
//   3. ROR A=0x000000F1 B=4 -> 0x1000000F; ROL A=0x80000001 B=1 -> 0x00000003; any op B=0 -> A.
//   4. out_ready=0, 4 requests tags 1..4 -> only tags 1,2 accepted, in_ready=0; Result held;
//      raise out_ready -> tags 1,2,3,4 emitted in order, none lost or duplicated.
//   5. Shiftop=001 A=0xFFFFFFFF B=5 tag=7 -> Result=0x00000000, out_tag=7, out_valid=1.
//   6. Two ops in flight, pulse rst mid-cycle -> out_valid=0 asynchronously; no output for the
//      dropped ops after release; next request completes with normal latency.

Source files
------------

// File: rtl/pipe_shifter_if.sv
// Request/result handshake bundle for pipe_shifter; slave is the shifter side.
interface pipe_shifter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 4
);
  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [SHAMT_W-1:0]    B;
  logic [2:0]            Shiftop;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Result;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output in_valid, A, B, Shiftop, in_tag, out_ready,
    input  in_ready, out_valid, Result, out_tag
  );

  modport slave (
    input  in_valid, A, B, Shiftop, in_tag, out_ready,
    output in_ready, out_valid, Result, out_tag
  );
endinterface

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (LL/RL/RA/ROL/ROR) with valid/ready on both sides and a pass-through
// tag. Shift levels are spread across PIPE_STAGES registered stages.
module pipe_shifter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input logic           clk,
  input logic           rst,
  pipe_shifter_if.slave bus
);
  localparam int unsigned SHAMT_W     = $clog2(DATA_WIDTH);
  localparam int unsigned LVL_PER_STG = (SHAMT_W + PIPE_STAGES - 1) / PIPE_STAGES;
  localparam int unsigned LAST        = PIPE_STAGES - 1;

  logic [PIPE_STAGES-1:0] valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q  [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]  data_d  [PIPE_STAGES];
  logic [SHAMT_W-1:0]     shamt_q [PIPE_STAGES];
  logic [SHAMT_W-1:0]     shamt_d [PIPE_STAGES];
  logic [2:0]             op_q    [PIPE_STAGES];
  logic [2:0]             op_d    [PIPE_STAGES];
  logic [TAG_WIDTH-1:0]   tag_q   [PIPE_STAGES];
  logic [TAG_WIDTH-1:0]   tag_d   [PIPE_STAGES];
  logic [PIPE_STAGES:0]   rdy;

  function automatic logic is_reserved(input logic [2:0] op);
    return op[0] && (op != 3'b011);
  endfunction

  // One level of the barrel: shift/rotate by 2^k in the direction given by op.
  function automatic logic [DATA_WIDTH-1:0] shift_level(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [2:0] op,
                                                        input int unsigned k);
    int unsigned n;
    logic signed [DATA_WIDTH-1:0] sd;
    n  = 32'd1 << k;
    sd = d;
    case (op)
      3'b000:  return d << n;
      3'b010:  return d >> n;
      3'b011:  return sd >>> n;
      3'b100:  return (d << n) | (d >> (DATA_WIDTH - n));
      3'b110:  return (d >> n) | (d << (DATA_WIDTH - n));
      default: return '0;
    endcase
  endfunction

  always_comb begin
    rdy              = '0;
    rdy[PIPE_STAGES] = bus.out_ready;
    for (int s = int'(LAST); s >= 0; s--) begin
      rdy[s] = !valid_q[s] | rdy[s+1];
    end
  end

  always_comb begin
    valid_d    = '0;
    valid_d[0] = bus.in_valid;
    data_d[0]  = is_reserved(bus.Shiftop) ? '0 : bus.A;
    shamt_d[0] = bus.B;
    op_d[0]    = bus.Shiftop;
    tag_d[0]   = bus.in_tag;
    for (int s = 1; s < int'(PIPE_STAGES); s++) begin
      valid_d[s] = valid_q[s-1];
      data_d[s]  = data_q[s-1];
      shamt_d[s] = shamt_q[s-1];
      op_d[s]    = op_q[s-1];
      tag_d[s]   = tag_q[s-1];
    end
    // Stage s applies levels s*LVL_PER_STG .. (s+1)*LVL_PER_STG-1 before registering.
    for (int s = 0; s < int'(PIPE_STAGES); s++) begin
      for (int k = 0; k < int'(SHAMT_W); k++) begin
        if ((k / int'(LVL_PER_STG)) == s && shamt_d[s][k]) begin
          data_d[s] = shift_level(data_d[s], op_d[s], k);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < int'(PIPE_STAGES); s++) begin
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        op_q[s]    <= '0;
        tag_q[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < int'(PIPE_STAGES); s++) begin
        if (rdy[s]) begin
          valid_q[s] <= valid_d[s];
          if (valid_d[s]) begin
            data_q[s]  <= data_d[s];
            shamt_q[s] <= shamt_d[s];
            op_q[s]    <= op_d[s];
            tag_q[s]   <= tag_d[s];
          end
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = valid_q[LAST];
  assign bus.Result    = data_q[LAST];
  assign bus.out_tag   = tag_q[LAST];

  // The final stage's shift amount and opcode have no consumer.
  logic unused_last;
  assign unused_last = ^{shamt_q[LAST], op_q[LAST]};
endmodule

// File: tb/tb_pipe_shifter.sv
// Directed bench for pipe_shifter: per-cycle scoreboard against a shift model plus literal checks.
module tb_pipe_shifter;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 4;

  localparam logic [2:0] OP_LL  = 3'b000;
  localparam logic [2:0] OP_RL  = 3'b010;
  localparam logic [2:0] OP_RA  = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  pipe_shifter_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  pipe_shifter #(.DATA_WIDTH(DW), .PIPE_STAGES(2), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] b,
                                        input logic [2:0] op);
    logic [63:0] dbl;
    case (op)
      OP_LL:  return a << b;
      OP_RL:  return a >> b;
      OP_RA:  return $signed(a) >>> b;
      OP_ROL: begin dbl = {a, a} << b; return dbl[63:32]; end
      OP_ROR: begin dbl = {a, a} >> b; return dbl[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  popped[$];
  logic        hold_v = 1'b0;
  logic [31:0] hold_res;
  logic [3:0]  hold_tag;

  // Scoreboard: all handshakes resolved at negedge reflect the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        nvec++;
        if (!bus.out_valid || bus.Result !== hold_res || bus.out_tag !== hold_tag) begin
          nerr++;
          $display("FAIL hold_stable: got v=%b res=%h tag=%h, required v=1 res=%h tag=%h",
                   bus.out_valid, bus.Result, bus.out_tag, hold_res, hold_tag);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        nvec++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL spurious_result: got tag=%h res=%h, required no output",
                   bus.out_tag, bus.Result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.Result !== e.res || bus.out_tag !== e.tag) begin
            nerr++;
            $display("FAIL scoreboard: got res=%h tag=%h, required res=%h tag=%h",
                     bus.Result, bus.out_tag, e.res, e.tag);
          end
          popped.push_back(bus.out_tag);
        end
      end
      hold_v   = bus.out_valid && !bus.out_ready;
      hold_res = bus.Result;
      hold_tag = bus.out_tag;
      if (bus.in_valid && bus.in_ready)
        sb.push_back('{res: model(bus.A, bus.B, bus.Shiftop), tag: bus.in_tag});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic send(input logic [31:0] a, input logic [4:0] b, input logic [2:0] op,
                      input logic [3:0] tag);
    int n;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.Shiftop  = op;
    bus.in_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      nerr++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [4:0] b,
                         input logic [2:0] op, input logic [3:0] tag, input logic [31:0] exp);
    send(a, b, op, tag);
    chk({name, "_lat_early"}, {31'h0, bus.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, {31'h0, bus.out_valid}, 32'h1);
    chk({name, "_result"}, bus.Result, exp);
    chk({name, "_tag"}, {28'h0, bus.out_tag}, {28'h0, tag});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rdy_seen;
    int         base;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Shiftop   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    #3;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_result", bus.Result, 32'h0);
    chk("rst_out_tag", {28'h0, bus.out_tag}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

    run_one("ll31", 32'h0000_0001, 5'd31, OP_LL, 4'd3, 32'h8000_0000);

    send(32'h8000_0000, 5'd4, OP_RA, 4'd5);
    send(32'h8000_0000, 5'd4, OP_RL, 4'd6);
    chk("b2b_ra_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("b2b_ra_result", bus.Result, 32'hF800_0000);
    chk("b2b_ra_tag", {28'h0, bus.out_tag}, 32'h5);
    @(posedge clk);
    #1;
    chk("b2b_rl_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("b2b_rl_result", bus.Result, 32'h0800_0000);
    chk("b2b_rl_tag", {28'h0, bus.out_tag}, 32'h6);
    @(posedge clk);
    #1;
    chk("b2b_drained", {31'h0, bus.out_valid}, 32'h0);

    run_one("ror4", 32'h0000_00F1, 5'd4, OP_ROR, 4'd1, 32'h1000_000F);
    run_one("rol1", 32'h8000_0001, 5'd1, OP_ROL, 4'd2, 32'h0000_0003);
    run_one("ll0",  32'hA5C3_0F96, 5'd0, OP_LL,  4'd4, 32'hA5C3_0F96);
    run_one("rl0",  32'hA5C3_0F96, 5'd0, OP_RL,  4'd5, 32'hA5C3_0F96);
    run_one("ra0",  32'hA5C3_0F96, 5'd0, OP_RA,  4'd6, 32'hA5C3_0F96);
    run_one("rol0", 32'hA5C3_0F96, 5'd0, OP_ROL, 4'd7, 32'hA5C3_0F96);
    run_one("ror0", 32'hA5C3_0F96, 5'd0, OP_ROR, 4'd8, 32'hA5C3_0F96);
    run_one("ra_pos", 32'h7000_0000, 5'd3, OP_RA, 4'd9, 32'h0E00_0000);
    @(posedge clk);
    #1;

    // Backpressure: only two requests fit while the consumer stalls.
    base = popped.size();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.A        = 32'h100 * i;
      bus.B        = 5'(i);
      bus.Shiftop  = OP_LL;
      bus.in_tag   = 4'(i);
      @(negedge clk);
      rdy_seen[i-1] = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("bp_in_ready_pattern", {28'h0, rdy_seen}, 32'h3);
    chk("bp_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
    chk("bp_held_result", bus.Result, 32'h0000_0200);
    chk("bp_held_tag", {28'h0, bus.out_tag}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_still_result", bus.Result, 32'h0000_0200);
    chk("bp_still_valid", {31'h0, bus.out_valid}, 32'h1);
    bus.out_ready = 1'b1;
    send(32'h0000_0300, 5'd3, OP_LL, 4'd3);
    send(32'h0000_0400, 5'd4, OP_LL, 4'd4);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_pop_count", popped.size() - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < popped.size())
        chk($sformatf("bp_order_%0d", i), {28'h0, popped[base+i]}, 32'(i + 1));
    end

    run_one("reserved", 32'hFFFF_FFFF, 5'd5, 3'b001, 4'd7, 32'h0000_0000);
    @(posedge clk);
    #1;

    // Mid-flight reset discards both operations.
    send(32'h0000_0011, 5'd1, OP_LL, 4'd8);
    send(32'h0000_0022, 5'd2, OP_LL, 4'd9);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("arst_result", bus.Result, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("arst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_no_stale_%0d", i), {31'h0, bus.out_valid}, 32'h0);
      @(posedge clk);
      #1;
    end
    run_one("post_rst", 32'h0000_0003, 5'd2, OP_LL, 4'd10, 32'h0000_000C);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
